divu_seq: RTL and testbench
===========================

// Module: divu_seq
// PURPOSE
//  Sequential restoring shift-subtract divider; the inverse datapath of the shift-add multiplier.
//  Computes one quotient bit per clock, reusing one WIDTH-bit subtractor (CLA_32 + not_gate_32, cin=1).
//  Sits beside the multiplier in the ALU's multi-cycle unit (MIPS divu/div).
// PARAMETERS
//  WIDTH      32   operand, quotient and remainder width; must be >= 2
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  reset      in   1      asynchronous, active-low; clears all state and outputs
//  a          in   WIDTH  dividend, sampled on the start edge only
//  b          in   WIDTH  divisor, sampled on the start edge only
//  doDiv      in   1      start request, level-sampled in IDLE
//  quotient   out  WIDTH  result quotient, held until next start
//  remainder  out  WIDTH  result remainder, held until next start
//  div_zero   out  1      high with results when b==0, held until next start
//  busy       out  1      high in RUN and DONE
//  div_done   out  1      one-cycle pulse, results valid from this cycle on
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; count, rem_quo reg [2*WIDTH-1:0], divisor reg,
//    quotient, remainder, div_zero, busy and div_done all 0.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: doDiv==1 at clk edge -> latch divisor=b, rem_quo={WIDTH'b0,a}, count=0, go RUN.
//  RUN, each cycle:
//    t = rem_quo<<1.
//    diff = t[2W-1:W] - divisor, computed at WIDTH+1 bits.
//    If diff is non-negative, rem_quo = {diff[W-1:0], t[W-1:1], 1'b1}; else rem_quo = t.
//    count++. After WIDTH RUN cycles, go DONE.
//  DONE (1 cycle):
//    quotient = rem_quo[W-1:0]; remainder = rem_quo[2W-1:W]; div_done=1; go IDLE.
//  Latency: start edge N -> div_done high in cycle N+WIDTH+1 (33 for W=32).
//    Next start is accepted at the first IDLE edge, giving a throughput of one op per WIDTH+2 cycles.
//  doDiv during RUN/DONE is ignored.
//    doDiv held high continuously restarts at the first IDLE edge, with a,b sampled then.
//  Divide by zero (b==0): still takes full latency (no early out).
//    The algorithm naturally gives quotient = all ones and remainder = a; div_zero=1 in DONE.
//  div_done is 0 in every cycle except DONE.
//    quotient, remainder and div_zero change only in DONE or on reset.
//  Reset asserted mid-operation aborts immediately: all outputs 0, no div_done pulse.
//  No simultaneous start+done hazard: start is only sampled in IDLE.
// CONFIGURATION
//  DIV_SIGNED_EN defined:
//    Extra input is_signed (1 bit), sampled with a,b.
//    When is_signed=1, operands are converted to magnitude at start.
//    In DONE, the quotient is negated iff sign(a)!=sign(b); the remainder takes sign(a).
//    Overflow MIN/-1 yields quotient=MIN (0x80000000), remainder=0.
//    Divide by zero yields quotient=all ones, remainder=a (unsigned pattern, no sign fix).
//    Latency is unchanged.
//  DIV_SIGNED_EN undefined: no is_signed port; unsigned only; no sign logic synthesized.
// TESTING
//  1. a=100, b=7, doDiv pulse -> div_done at cycle 33; quotient=14, remainder=2, div_zero=0.
//  2. a=0x1234, b=0 -> cycle 33: quotient=0xFFFFFFFF, remainder=0x1234, div_zero=1.
//  3. a=0xFFFFFFFF, b=1 -> quotient=0xFFFFFFFF, remainder=0.
//     a=5, b=9 -> quotient=0, remainder=5.
//  4. Reset low at cycle 10 of RUN -> busy=0, outputs 0, no div_done.
//     After release, a=9, b=3 -> quotient=3, remainder=0.
//  5. doDiv held high across two ops (a=50,b=5 then a=51,b=5) -> done pulses exactly 34 cycles apart.
//     Results 10 r0, then 10 r1; a/b changes during RUN have no effect.
//  6. DIV_SIGNED_EN, is_signed=1:
//     -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
//     0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
//     is_signed=0, -7/2 -> quotient=0x7FFFFFFC, remainder=1.

Source files
------------

// File: rtl/divu_seq.sv
// divu_seq: restoring shift-subtract divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to add the is_signed port and two's-complement sign handling.
module divu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic             doDiv,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             busy,
  output logic             div_done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   rem_quo_q, rem_quo_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic [WIDTH-1:0]     quotient_q, quotient_d, remainder_q, remainder_d;
  logic                 div_zero_q, div_zero_d;
  logic [WIDTH-1:0]     dividend, b_mag;
  logic [WIDTH:0]       diff;
`ifdef DIV_SIGNED_EN
  logic                 qneg_q, qneg_d, rneg_q, rneg_d, a_neg, b_neg;
`endif
  always_comb begin
`ifdef DIV_SIGNED_EN
    a_neg    = is_signed & a[WIDTH-1] & (b != '0);
    b_neg    = is_signed & b[WIDTH-1];
    dividend = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
`else
    dividend = a;
    b_mag    = b;
`endif
    // the bit shifted out of the partial remainder joins the compare so large divisors stay exact
    diff        = rem_quo_q[2*WIDTH-1:WIDTH-1] - {1'b0, divisor_q};
    state_d     = state_q;
    count_d     = count_q;
    rem_quo_d   = rem_quo_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    case (state_q)
      IDLE: if (doDiv) begin
        state_d   = RUN;
        divisor_d = b_mag;
        rem_quo_d = {{WIDTH{1'b0}}, dividend};
        count_d   = '0;
`ifdef DIV_SIGNED_EN
        qneg_d    = is_signed & (b != '0) & (a[WIDTH-1] ^ b[WIDTH-1]);
        rneg_d    = a_neg;
`endif
      end
      RUN: begin
        rem_quo_d = diff[WIDTH] ? {rem_quo_q[2*WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], rem_quo_q[WIDTH-2:0], 1'b1};
        count_d   = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          div_zero_d  = (divisor_q == '0);
`ifdef DIV_SIGNED_EN
          quotient_d  = qneg_q ? -rem_quo_d[WIDTH-1:0] : rem_quo_d[WIDTH-1:0];
          remainder_d = rneg_q ? -rem_quo_d[2*WIDTH-1:WIDTH] : rem_quo_d[2*WIDTH-1:WIDTH];
`else
          quotient_d  = rem_quo_d[WIDTH-1:0];
          remainder_d = rem_quo_d[2*WIDTH-1:WIDTH];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_quo_q   <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_quo_q   <= rem_quo_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
`ifdef DIV_SIGNED_EN
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
`endif
    end
  end
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign busy      = (state_q != IDLE);
  assign div_done  = (state_q == DONE);
endmodule

// File: tb/tb_divu_seq.sv
// tb_divu_seq: randomized and directed checks of divu_seq against an arithmetic reference model.
module tb_divu_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        doDiv = 1'b0;
  logic        is_s = 1'b0;
  logic [31:0] quotient, remainder;
  logic        div_zero, busy, div_done;
  int          checks = 0, failures = 0;

  divu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
`ifdef DIV_SIGNED_EN
    .is_signed(is_s),
`endif
    .doDiv(doDiv), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .busy(busy), .div_done(div_done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
    if (y == 0) return {32'hFFFF_FFFF, x};
    if (s) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      return {32'($signed(x) / $signed(y)), 32'($signed(x) % $signed(y))};
    end
    return {x / y, x % y};
  endfunction

  task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, output int lat, output logic bs);
    @(posedge clk); #1;
    a = ai; b = bi; doDiv = 1'b1;
    @(posedge clk); #1;
    doDiv = 1'b0; a = $urandom; b = $urandom; bs = busy; lat = 0;
    while (div_done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (div_done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0; doDiv = 1'b1; a = 32'd77; b = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (quotient !== 0)  begin failures++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
    if (remainder !== 0) begin failures++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
    if (div_zero !== 0)  begin failures++; $display("FAIL reset_div_zero got=%b exp=0", div_zero); end
    if (busy !== 0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (div_done !== 0)  begin failures++; $display("FAIL reset_div_done got=%b exp=0", div_done); end
    doDiv = 1'b0;
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] av[6] = '{32'd100, 32'h1234, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0001};
    logic [31:0] bv[6] = '{32'd7, 32'd0, 32'd1, 32'd9, 32'h8000_0001, 32'hFFFF_FFFF};
    int lat;
    logic bs;
    logic [63:0] e;
    is_s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e = ref_div(av[i], bv[i], 1'b0);
      run_op(av[i], bv[i], lat, bs);
      checks += 6;
      if (lat !== 32)              begin failures++; $display("FAIL dir_latency[%0d] got=%0d exp=32", i, lat); end
      if (bs !== 1'b1)             begin failures++; $display("FAIL dir_busy[%0d] got=%b exp=1", i, bs); end
      if (quotient !== e[63:32])   begin failures++; $display("FAIL dir_quotient[%0d] got=%h exp=%h", i, quotient, e[63:32]); end
      if (remainder !== e[31:0])   begin failures++; $display("FAIL dir_remainder[%0d] got=%h exp=%h", i, remainder, e[31:0]); end
      if (div_zero !== (bv[i] == 0)) begin failures++; $display("FAIL dir_div_zero[%0d] got=%b exp=%b", i, div_zero, bv[i] == 0); end
      @(posedge clk); #1;
      if (div_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL dir_idle[%0d] done=%b busy=%b exp=0,0", i, div_done, busy); end
    end
  endtask

  task automatic test_random();
    int lat;
    logic bs;
    logic [31:0] x, y;
    logic [63:0] e;
    is_s = 1'b0;
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 4 == 1) y = y >> $urandom_range(1, 31);
      if (i % 10 == 7) y = 0;
      e = ref_div(x, y, 1'b0);
      run_op(x, y, lat, bs);
      checks += 4;
      if (lat !== 32)            begin failures++; $display("FAIL rnd_latency[%0d] got=%0d exp=32", i, lat); end
      if (quotient !== e[63:32]) begin failures++; $display("FAIL rnd_quotient[%0d] %h/%h got=%h exp=%h", i, x, y, quotient, e[63:32]); end
      if (remainder !== e[31:0]) begin failures++; $display("FAIL rnd_remainder[%0d] %h/%h got=%h exp=%h", i, x, y, remainder, e[31:0]); end
      if (div_zero !== (y == 0)) begin failures++; $display("FAIL rnd_div_zero[%0d] got=%b exp=%b", i, div_zero, y == 0); end
      a = $urandom; b = $urandom;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (quotient !== e[63:32] || remainder !== e[31:0] || div_done !== 1'b0)
        begin failures++; $display("FAIL rnd_hold[%0d] q=%h r=%h done=%b exp=%h,%h,0", i, quotient, remainder, div_done, e[63:32], e[31:0]); end
    end
  endtask

  task automatic test_abort();
    int lat;
    logic bs, seen;
    @(posedge clk); #1;
    a = 32'd1000; b = 32'd3; doDiv = 1'b1;
    @(posedge clk); #1;
    doDiv = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks += 4;
    if (busy !== 0)      begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    if (quotient !== 0)  begin failures++; $display("FAIL abort_quotient got=%h exp=0", quotient); end
    if (remainder !== 0) begin failures++; $display("FAIL abort_remainder got=%h exp=0", remainder); end
    if (div_zero !== 0)  begin failures++; $display("FAIL abort_div_zero got=%b exp=0", div_zero); end
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; seen |= div_done; end
    @(negedge clk) reset = 1'b1;
    repeat (35) begin @(posedge clk); #1; seen |= div_done; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", seen); end
    run_op(32'd9, 32'd3, lat, bs);
    checks += 3;
    if (lat !== 32)        begin failures++; $display("FAIL abort_after_latency got=%0d exp=32", lat); end
    if (quotient !== 3)    begin failures++; $display("FAIL abort_after_quotient got=%h exp=3", quotient); end
    if (remainder !== 0)   begin failures++; $display("FAIL abort_after_remainder got=%h exp=0", remainder); end
  endtask

  task automatic test_back_to_back();
    int n, g;
    @(posedge clk); #1;
    a = 32'd50; b = 32'd5; doDiv = 1'b1;
    @(posedge clk); #1;
    a = 32'd51;
    n = 0;
    while (div_done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    checks += 3;
    if (n !== 32)        begin failures++; $display("FAIL b2b_first_latency got=%0d exp=32", n); end
    if (quotient !== 10) begin failures++; $display("FAIL b2b_first_quotient got=%h exp=10", quotient); end
    if (remainder !== 0) begin failures++; $display("FAIL b2b_first_remainder got=%h exp=0", remainder); end
    g = 0;
    do begin
      @(posedge clk); #1;
      g++;
      if (g == 3) begin a = 32'd99; b = 32'd1; end
    end while (div_done !== 1'b1 && g < 100);
    doDiv = 1'b0;
    checks += 3;
    if (g !== 34)        begin failures++; $display("FAIL b2b_gap got=%0d exp=34", g); end
    if (quotient !== 10) begin failures++; $display("FAIL b2b_second_quotient got=%h exp=10", quotient); end
    if (remainder !== 1) begin failures++; $display("FAIL b2b_second_remainder got=%h exp=1", remainder); end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (busy !== 0) begin failures++; $display("FAIL b2b_stop_busy got=%b exp=0", busy); end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    logic [31:0] av[5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9};
    logic [31:0] bv[5] = '{32'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd0};
    logic        sv[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int lat;
    logic bs;
    logic [31:0] x, y;
    logic [63:0] e;
    for (int i = 0; i < 25; i++) begin
      if (i < 5) begin x = av[i]; y = bv[i]; is_s = sv[i]; end
      else begin x = $urandom; y = $urandom >> $urandom_range(0, 31); is_s = 1'($urandom); end
      e = ref_div(x, y, is_s);
      run_op(x, y, lat, bs);
      checks += 3;
      if (lat !== 32)            begin failures++; $display("FAIL sgn_latency[%0d] got=%0d exp=32", i, lat); end
      if (quotient !== e[63:32]) begin failures++; $display("FAIL sgn_quotient[%0d] s=%b %h/%h got=%h exp=%h", i, is_s, x, y, quotient, e[63:32]); end
      if (remainder !== e[31:0]) begin failures++; $display("FAIL sgn_remainder[%0d] s=%b %h/%h got=%h exp=%h", i, is_s, x, y, remainder, e[31:0]); end
    end
    is_s = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_back_to_back();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
